// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Owns the single write port of the register file. x0 is hardwired to zero.
//   After reset it clears x1..x(2**ADDR_W-1) to INIT_VALUE, one register per cycle.
//   It then shares the write port between two requesters using round-robin
//   arbitration with a valid/ready handshake:
//     requester 0 = ALU writeback, requester 1 = load/debug writeback.
//   Every accepted write reaches wr_* exactly one cycle after its handshake.
//
// Ports
//   clk, rst                            clock (rising edge), synchronous active-high reset
//   req0_valid/addr/data, req0_ready    requester 0 handshake
//   req1_valid/addr/data, req1_ready    requester 1 handshake
//   wr_ena, wr_addr, wr_data            registered register-file write port
//   init_done                           registered; high once the clear sweep has issued
module regfile_write_arbiter #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 5,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              last_grant_reg;
  logic              wr_ena_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              init_done_reg;

  logic [1:0]        valid;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;

  assign valid = {req1_valid, req0_valid};

  // Round-robin: on contention the requester that did not win last time goes.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // init_done is only ever set on entry to S_RUN, so it doubles as the
  // "arbitration open" qualifier for both readies.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready[gi] = init_done_reg & grant[gi];
    end
  endgenerate

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  // At most one ready is high, so a two-way mux selects the winner.
  assign addr_sel = ready[1] ? req1_addr : req0_addr;
  assign data_sel = ready[1] ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_INIT;
      ptr_reg        <= FIRST_ADDR;
      last_grant_reg <= 1'b1;
      wr_ena_reg     <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      init_done_reg  <= 1'b0;
    end else if (state_reg == S_INIT) begin
      wr_ena_reg  <= 1'b1;
      wr_addr_reg <= ptr_reg;
      wr_data_reg <= INIT_VALUE;
      ptr_reg     <= ptr_reg + 1'b1;
      // init_done rises together with the last sweep write.
      if (ptr_reg == LAST_ADDR) begin
        state_reg     <= S_RUN;
        init_done_reg <= 1'b1;
      end
    end else begin
      if (|ready) begin
        // A write to x0 is accepted but never reaches the register file.
        wr_ena_reg     <= (addr_sel != '0);
        wr_addr_reg    <= addr_sel;
        wr_data_reg    <= data_sel;
        last_grant_reg <= ready[1];
      end else begin
        wr_ena_reg <= 1'b0;
      end
    end
  end

  assign wr_ena    = wr_ena_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign init_done = init_done_reg;

endmodule
